// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman array sequencer.
package sw_pkg;

    localparam int SCORE_W = 12;
    localparam logic signed [SCORE_W-1:0] NEG_INF = 12'sh900;

    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } base_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADQ,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sw_tap_sel.sv
// Picks the MAX/V outputs of one PE by index and reduces them to a
// non-negative alignment score.
module sw_tap_sel
    import sw_pkg::*;
#(
    parameter int N     = 16,
    parameter int LEN_W = 10,
    parameter int SW    = SCORE_W
) (
    input  logic [SW*N-1:0]  arr_max,
    input  logic [SW*N-1:0]  arr_v,
    input  logic [LEN_W-1:0] idx,
    output logic [SW-1:0]    score
);

    logic signed [SW-1:0] max_sel;
    logic signed [SW-1:0] v_sel;

    function automatic logic signed [SW-1:0] max_s(input logic signed [SW-1:0] a,
                                                   input logic signed [SW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [SW-1:0] clamp_pos(input logic signed [SW-1:0] a);
        return a[SW-1] ? '0 : a;
    endfunction

    // An out-of-range index selects nothing and yields a zero score.
    always_comb begin
        max_sel = '0;
        v_sel   = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == LEN_W'(i)) begin
                max_sel = arr_max[i*SW +: SW];
                v_sel   = arr_v[i*SW +: SW];
            end
        end
    end

    assign score = clamp_pos(max_s(max_sel, v_sel));

endmodule

// File: rtl/sw_array_ctrl.sv
// Job sequencer for the Smith-Waterman systolic array: loads the query,
// streams the target as a gap-free wavefront and returns the tapped score.
module sw_array_ctrl
    import sw_pkg::*;
#(
    parameter int N     = 16,
    parameter int LEN_W = 10,
    parameter int SW    = SCORE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [LEN_W-1:0]  q_len,
    input  logic [LEN_W-1:0]  t_len,
    output logic              q_rd_en,
    output logic [LEN_W-1:0]  q_rd_addr,
    input  logic [1:0]        q_rd_data,
    output logic              t_rd_en,
    output logic [LEN_W-1:0]  t_rd_addr,
    input  logic [1:0]        t_rd_data,
    output logic [2*N-1:0]    pe_S,
    output logic              pe_changeS,
    output logic [1:0]        pe_T,
    output logic              pe_init,
    output logic [SW-1:0]     pe_V_in,
    output logic [SW-1:0]     pe_MAX_in,
    output logic [SW-1:0]     pe_F_in,
    input  logic [SW*N-1:0]   arr_max,
    input  logic [SW*N-1:0]   arr_v,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SW-1:0]     res_score,
    output logic              res_err
);

    localparam logic [LEN_W-1:0] N_L = LEN_W'(N);

    state_e           state;
    state_e           state_n;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] q_len_r;
    logic [LEN_W-1:0] t_len_r;
    logic [LEN_W-1:0] tap_idx;
    logic [2*N-1:0]   pe_s_r;
    logic             q_vld_p0;
    logic [LEN_W-1:0] q_idx_p0;
    logic             init_p0;
    logic             chg_p0;
    logic [SW-1:0]    tap_score;
    logic [SW-1:0]    res_score_r;
    logic             res_err_r;
    logic             hs;
    logic             len_bad;
    logic             load_last;
    logic             stream_last;
    logic             drain_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        start_ready = 1'b0;
        q_rd_en     = 1'b0;
        t_rd_en     = 1'b0;
        res_valid   = 1'b0;
        hs          = 1'b0;
        load_last   = 1'b0;
        stream_last = 1'b0;
        drain_last  = 1'b0;
        len_bad     = (q_len == '0) || (q_len > N_L) || (t_len == '0);
        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
                hs          = start_valid;
                if (hs) begin
                    state_n = len_bad ? ST_DONE : ST_LOADQ;
                end
            end
            // One extra cycle lets the last query read land in pe_S.
            ST_LOADQ: begin
                q_rd_en   = (cnt < q_len_r);
                load_last = (cnt == q_len_r);
                if (load_last) begin
                    state_n = ST_STREAM;
                end
            end
            ST_STREAM: begin
                t_rd_en     = (cnt < t_len_r);
                stream_last = (cnt == t_len_r);
                if (stream_last) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_last = (cnt == q_len_r - LEN_W'(1));
                if (drain_last) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Stage p0: read strobes delayed to line up with the RAM data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            q_len_r     <= '0;
            t_len_r     <= '0;
            pe_s_r      <= '0;
            q_vld_p0    <= 1'b0;
            q_idx_p0    <= '0;
            init_p0     <= 1'b0;
            chg_p0      <= 1'b0;
            res_score_r <= '0;
            res_err_r   <= 1'b0;
        end else begin
            q_vld_p0 <= q_rd_en;
            q_idx_p0 <= cnt;
            init_p0  <= t_rd_en;
            chg_p0   <= t_rd_en && (cnt == '0);

            if (q_vld_p0) begin
                for (int i = 0; i < N; i++) begin
                    if (q_idx_p0 == LEN_W'(i)) begin
                        pe_s_r[2*i +: 2] <= q_rd_data;
                    end
                end
            end

            if (load_last || stream_last) begin
                cnt <= '0;
            end else if (state == ST_LOADQ || state == ST_STREAM || state == ST_DRAIN) begin
                cnt <= cnt + LEN_W'(1);
            end

            if (hs) begin
                q_len_r     <= q_len;
                t_len_r     <= t_len;
                cnt         <= '0;
                pe_s_r      <= '0;
                res_score_r <= '0;
                res_err_r   <= len_bad;
            end

            if (drain_last) begin
                res_score_r <= tap_score;
                cnt         <= '0;
            end

            if (state == ST_DONE && res_ready) begin
                res_score_r <= '0;
                res_err_r   <= 1'b0;
            end
        end
    end

    assign tap_idx = q_len_r - LEN_W'(1);

    sw_tap_sel #(
        .N     (N),
        .LEN_W (LEN_W),
        .SW    (SW)
    ) u_tap_sel (
        .arr_max (arr_max),
        .arr_v   (arr_v),
        .idx     (tap_idx),
        .score   (tap_score)
    );

    assign q_rd_addr  = q_rd_en ? cnt : '0;
    assign t_rd_addr  = t_rd_en ? cnt : '0;
    assign pe_S       = pe_s_r;
    assign pe_init    = init_p0;
    assign pe_changeS = chg_p0;
    assign pe_T       = init_p0 ? t_rd_data : 2'b00;
    assign pe_V_in    = '0;
    assign pe_MAX_in  = '0;
    assign pe_F_in    = SW'(NEG_INF);
    assign res_score  = res_score_r;
    assign res_err    = res_err_r;

endmodule
